// File: rtl/interrupt_controller.sv
// ============================================================================
//  interrupt_controller
//  Fixed-priority interrupt controller with rising-edge request capture.
//  It presents a request/acknowledge/end-of-service vector handshake to the CPU.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_controller #(
   parameter int         NUM_SRC  = 4,
   parameter logic [7:0] VEC_BASE = 8'd1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_req,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_in,
   input  logic               int_ack,
   input  logic               int_done,
   output logic [7:0]         interrupcion,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy
);

   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQUEST = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   logic [1:0]         r_state;
   logic [NUM_SRC-1:0] r_req_d;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [SEL_W-1:0]   r_sel;
   logic [7:0]         r_vec;
   logic               r_busy;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_clr;
   logic [SEL_W-1:0]   w_sel;

   assign w_edge     = irq_req & ~r_req_d;
   assign w_eligible = r_pending & ~r_mask;

   // Scan downward so the lowest set index (highest priority) is the final winner.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) w_sel = SEL_W'(i);
      end
   end

   always_comb begin
      w_clr = '0;
      if (r_state == S_REQUEST && int_ack) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = (r_sel == SEL_W'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_req_d   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_sel     <= '0;
         r_vec     <= 8'd0;
         r_busy    <= 1'b0;
      end else begin
         r_req_d   <= irq_req;
         // A new edge on the source being acknowledged survives the clear.
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if (mask_we) r_mask <= mask_in;

         case (r_state)
            S_IDLE: begin
               if (|w_eligible) begin
                  r_sel   <= w_sel;
                  r_vec   <= VEC_BASE + 8'(w_sel);
                  r_busy  <= 1'b1;
                  r_state <= S_REQUEST;
               end else begin
                  r_vec <= 8'd0;
               end
            end
            S_REQUEST: begin
               if (int_ack) begin
                  r_vec   <= 8'd0;
                  r_state <= S_SERVICE;
               end else if (r_mask[r_sel]) begin
                  r_vec   <= 8'd0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_SERVICE: begin
               if (int_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_vec   <= 8'd0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign interrupcion = r_vec;
   assign pending      = r_pending;
   assign busy         = r_busy;

endmodule

`default_nettype wire
